// File: rtl/can_crc_tx_seq_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Shared types and constants for the CAN CRC-15 transmit sequencer.
//   state_e        : sequencer states (IDLE, CLR, DATA, CRC, DELIM)
//   CAN_CRC_W      : CRC field width in bits
//   CAN_STUFF_RUN  : run length of equal bits that forces a stuff bit
//   CAN_RECESSIVE  : recessive bus level
//   CAN_MAX_LEN    : default maximum frame-prefix length (standard frame, 8 bytes)
// ---------------------------------------------------------------------------
package can_pkg;

    localparam int   CAN_CRC_W     = 15;
    localparam int   CAN_STUFF_RUN = 5;
    localparam logic CAN_RECESSIVE = 1'b1;
    localparam int   CAN_MAX_LEN   = 83;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        DATA,
        CRC,
        DELIM
    } state_e;

endpackage

// File: rtl/can_crc_tx_seq_if.sv
// ---------------------------------------------------------------------------
// can_crc_tx_seq_if
// Signal bundle between the frame assembler / CRC unit / TX pin logic
// (master side) and the transmit sequencer (slave side).
//   bit_tick   : one-cycle pulse per nominal bit time
//   start      : frame request, accepted in IDLE with len != 0
//   abort      : synchronous abort back to IDLE
//   len        : number of prefix bits (values > MAX_LEN clamp to MAX_LEN)
//   frame      : prefix bits, frame[len-1] is sent first
//   crc_in     : CRC register from the CRC unit
//   crc_clear  : CRC unit clear
//   crc_bitval : bit presented to the CRC unit
//   crc_strb   : CRC unit strobe (unit captures on its rising edge)
//   tx_bit     : serial output, 1 = recessive
//   busy       : frame in progress
//   done       : one-cycle completion pulse
// ---------------------------------------------------------------------------
interface can_crc_tx_seq_if
    import can_pkg::*;
#(
    parameter int MAX_LEN = CAN_MAX_LEN
) ();
    localparam int LW = $clog2(MAX_LEN + 1);

    logic                 bit_tick;
    logic                 start;
    logic                 abort;
    logic [LW-1:0]        len;
    logic [MAX_LEN-1:0]   frame;
    logic [CAN_CRC_W-1:0] crc_in;
    logic                 crc_clear;
    logic                 crc_bitval;
    logic                 crc_strb;
    logic                 tx_bit;
    logic                 busy;
    logic                 done;

    modport master (
        output bit_tick, start, abort, len, frame, crc_in,
        input  crc_clear, crc_bitval, crc_strb, tx_bit, busy, done
    );

    modport slave (
        input  bit_tick, start, abort, len, frame, crc_in,
        output crc_clear, crc_bitval, crc_strb, tx_bit, busy, done
    );

endinterface

// File: rtl/can_crc_tx_seq_stuffer.sv
// ---------------------------------------------------------------------------
// can_bit_stuffer
// Run counter and stuff decision for the CAN transmit path.
// Configuration macro: CAN_TX_STUFF_EN (undefined: pass-through, no stuffing).
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart the run (start of frame / abort)
//   tick      : a bit is being emitted this cycle
//   enable    : inside the stuffing region
//   next_bit  : next frame bit the sequencer wants to send
//   bit_out   : bit actually placed on the wire
//   is_stuff  : bit_out is a stuff bit (frame does not advance)
// ---------------------------------------------------------------------------
module can_bit_stuffer
    import can_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    input  logic enable,
    input  logic next_bit,
    output logic bit_out,
    output logic is_stuff
);

`ifdef CAN_TX_STUFF_EN
    logic [2:0] run_q, run_d;
    logic       last_q, last_d;

    // NOTE: every signal written in always_comb gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        is_stuff = enable && (run_q == 3'(CAN_STUFF_RUN));
        bit_out  = is_stuff ? ~last_q : next_bit;
        run_d    = run_q;
        last_d   = last_q;
        if (clear) begin
            run_d  = '0;
            last_d = CAN_RECESSIVE;
        end else if (tick && enable) begin
            // A stuff bit, a fresh run or a level change all restart at 1.
            if (is_stuff || run_q == '0 || next_bit != last_q) begin
                run_d  = 3'd1;
                last_d = bit_out;
            end else begin
                run_d = run_q + 3'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= '0;
            last_q <= CAN_RECESSIVE;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end
`else
    assign bit_out  = next_bit;
    assign is_stuff = 1'b0;

    wire unused_stuff_inputs = &{1'b0, clk, rst, clear, tick, enable};
`endif

endmodule

// File: rtl/can_crc_tx_seq.sv
// ---------------------------------------------------------------------------
// can_crc_tx_seq
// Transmit-side sequencer for the CAN CRC-15 unit: serialises a latched frame
// prefix MSB-first, strobes each prefix bit into the external CRC unit,
// appends the 15-bit CRC and the recessive CRC delimiter, inserting stuff
// bits through the last CRC bit.
// Configuration macro: CAN_TX_STUFF_EN (defined: bit stuffing enabled).
//   clk  : block clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : can_crc_tx_seq_if.slave (tick/start/abort/len/frame/crc_in in;
//          crc_clear/crc_bitval/crc_strb/tx_bit/busy/done out)
// ---------------------------------------------------------------------------
module can_crc_tx_seq
    import can_pkg::*;
#(
    parameter int MAX_LEN = CAN_MAX_LEN
) (
    input  logic             clk,
    input  logic             rst,
    can_crc_tx_seq_if.slave  bus
);
    localparam int LW = $clog2(MAX_LEN + 1);

    state_e               state_q, state_d;
    logic [MAX_LEN-1:0]   frame_q, frame_d;
    logic [LW-1:0]        idx_q, idx_d;          // prefix bits still to send
    logic [CAN_CRC_W-1:0] crc_sreg_q, crc_sreg_d;
    logic [3:0]           crc_cnt_q, crc_cnt_d;  // CRC bits already sent
    logic                 delim_sent_q, delim_sent_d;
    logic                 tx_bit_q, tx_bit_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 crc_clear_q, crc_clear_d;
    logic                 crc_strb_q, crc_strb_d;
    logic                 crc_bitval_q, crc_bitval_d;
    logic                 strb_pend_q, strb_pend_d;

    logic [LW-1:0]        len_clamped;
    logic [LW-1:0]        bit_idx;
    logic                 next_bit, wire_bit, is_stuff;
    logic                 stuff_en, stuff_tick, stuff_clear;

    always_comb begin
        len_clamped = (bus.len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.len;
        bit_idx     = idx_q - 1'b1;
        case (state_q)
            DATA:    next_bit = frame_q[bit_idx];
            // The CRC register is read live for the first CRC bit; that tick
            // is also the one that loads the shift register.
            CRC:     next_bit = (crc_cnt_q == '0) ? bus.crc_in[CAN_CRC_W-1]
                                                  : crc_sreg_q[CAN_CRC_W-1];
            default: next_bit = CAN_RECESSIVE;
        endcase
        // The delimiter tick still checks for a pending stuff bit that
        // follows the last CRC bit; the delimiter itself is never stuffed.
        stuff_en    = (state_q == DATA) || (state_q == CRC) ||
                      (state_q == DELIM && !delim_sent_q);
        stuff_tick  = bus.bit_tick && !bus.abort && stuff_en;
        stuff_clear = (state_q == IDLE) || bus.abort;
    end

    can_bit_stuffer u_stuffer (
        .clk      (clk),
        .rst      (rst),
        .clear    (stuff_clear),
        .tick     (stuff_tick),
        .enable   (stuff_en),
        .next_bit (next_bit),
        .bit_out  (wire_bit),
        .is_stuff (is_stuff)
    );

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        idx_d        = idx_q;
        crc_sreg_d   = crc_sreg_q;
        crc_cnt_d    = crc_cnt_q;
        delim_sent_d = delim_sent_q;
        tx_bit_d     = tx_bit_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        crc_clear_d  = 1'b0;
        strb_pend_d  = 1'b0;
        // Strobe trails the TX_BIT change by one cycle; the bit value comes
        // from the wire register, which still holds the bit just emitted.
        crc_strb_d   = strb_pend_q;
        crc_bitval_d = strb_pend_q ? tx_bit_q : crc_bitval_q;

        if (state_q != IDLE && bus.abort) begin
            state_d    = IDLE;
            tx_bit_d   = CAN_RECESSIVE;
            busy_d     = 1'b0;
            crc_strb_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && bus.len != '0) begin
                        state_d      = CLR;
                        frame_d      = bus.frame;
                        idx_d        = len_clamped;
                        crc_cnt_d    = '0;
                        delim_sent_d = 1'b0;
                        busy_d       = 1'b1;
                        crc_clear_d  = 1'b1;
                    end
                end
                CLR: state_d = DATA;
                DATA: begin
                    if (bus.bit_tick) begin
                        tx_bit_d = wire_bit;
                        if (!is_stuff) begin
                            strb_pend_d = 1'b1;
                            idx_d       = idx_q - 1'b1;
                            if (idx_q == LW'(1)) state_d = CRC;
                        end
                    end
                end
                CRC: begin
                    if (bus.bit_tick) begin
                        tx_bit_d = wire_bit;
                        if (!is_stuff) begin
                            crc_sreg_d = (crc_cnt_q == '0)
                                       ? {bus.crc_in[CAN_CRC_W-2:0], 1'b0}
                                       : {crc_sreg_q[CAN_CRC_W-2:0], 1'b0};
                            crc_cnt_d  = crc_cnt_q + 4'd1;
                            if (crc_cnt_q == 4'(CAN_CRC_W - 1)) state_d = DELIM;
                        end
                    end
                end
                DELIM: begin
                    if (bus.bit_tick) begin
                        if (!delim_sent_q) begin
                            tx_bit_d     = wire_bit;
                            delim_sent_d = !is_stuff;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            crc_cnt_q    <= '0;
            delim_sent_q <= 1'b0;
            tx_bit_q     <= CAN_RECESSIVE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            crc_clear_q  <= 1'b0;
            crc_strb_q   <= 1'b0;
            crc_bitval_q <= 1'b0;
            strb_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            crc_cnt_q    <= crc_cnt_d;
            delim_sent_q <= delim_sent_d;
            tx_bit_q     <= tx_bit_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            crc_clear_q  <= crc_clear_d;
            crc_strb_q   <= crc_strb_d;
            crc_bitval_q <= crc_bitval_d;
            strb_pend_q  <= strb_pend_d;
        end
    end

    // NOTE: pure datapath storage is left without reset; it is always loaded
    // before it is read, so a reset would only add routing to wide registers.
    always_ff @(posedge clk) begin
        frame_q    <= frame_d;
        crc_sreg_q <= crc_sreg_d;
    end

    assign bus.tx_bit     = tx_bit_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.crc_clear  = crc_clear_q;
    assign bus.crc_strb   = crc_strb_q;
    assign bus.crc_bitval = crc_bitval_q;

endmodule

// File: doc/can_crc_tx_seq.md
# can_crc_tx_seq

Transmit-side sequencer for the CAN CRC-15 LFSR unit. It takes a parallel, pre-assembled frame prefix (SOF through end of data field) and serialises it MSB-first at one bit per BIT_TICK. For each frame bit it drives the CRC unit's clear, value and strobe inputs, then appends the computed 15-bit CRC and the recessive CRC delimiter. Bit stuffing is inserted on the wire. The block sits between the frame assembler and the bit-timing/TX pin logic.

## Interface
- MAX_LEN, 83: maximum frame-prefix length in bits (standard frame, 8 data bytes)
- LW, $clog2(MAX_LEN+1): width of LEN
- CLK  in  1  block clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- BIT_TICK  in  1  one-cycle pulse per nominal bit time; consecutive ticks ≥3 CLK apart
- START  in  1  request; accepted only in IDLE with LEN≠0
- ABORT  in  1  synchronous abort; returns to IDLE
- LEN  in  LW  number of prefix bits to send (1..MAX_LEN; values >MAX_LEN are treated as MAX_LEN)
- FRAME  in  MAX_LEN  prefix bits; the first bit sent is FRAME[LEN-1], the last is FRAME[0]; sampled on START acceptance
- CRC_IN  in  15  CRC register from the CRC unit
- CRC_CLEAR  out  1  CRC unit clear
- CRC_BITVAL  out  1  bit presented to the CRC unit
- CRC_STRB  out  1  CRC unit bit strobe (the unit captures on its rising edge)
- TX_BIT  out  1  serial output; 1 = recessive
- BUSY  out  1  high from START acceptance until DONE
- DONE  out  1  one-cycle completion pulse

## Operation
- Reset values:
  - TX_BIT=1; BUSY, DONE, CRC_CLEAR, CRC_STRB and CRC_BITVAL = 0
  - state IDLE; stuff counter = 0
- States and transitions:
  - IDLE → CLR on an accepted START. FRAME and LEN are latched; CRC_CLEAR=1 for exactly one cycle.
  - CLR → DATA on the next cycle.
  - DATA: on each BIT_TICK, emit the next prefix bit. Unless it is a stuff bit, set CRC_BITVAL to the bit and pulse CRC_STRB high for one cycle starting the cycle after the tick. After LEN non-stuff bits, go to CRC.
  - CRC: on the first tick in this state, latch CRC_IN into a 15-bit shift register, then emit CRC[14] first. Emit 15 bits; no CRC strobes are issued. Then go to DELIM.
  - DELIM: on a tick, TX_BIT=1 (never stuffed). On the following tick go to IDLE, with DONE=1 for one cycle and BUSY=0.
- Stuffing:
  - The run counter tracks consecutive equal TX_BIT values, stuff bits included.
  - After 5 equal bits, the next tick emits their complement instead of advancing; the counter restarts at 1 with that complement.
  - Stuffing applies from SOF through the last CRC bit, including a stuff bit that falls immediately after the last CRC bit, before DELIM.
  - Stuff bits never strobe the CRC unit.
- START while BUSY is ignored. START with LEN=0 is ignored; DONE is not asserted.
- ABORT (any non-IDLE state) has priority over BIT_TICK:
  - next cycle: IDLE, TX_BIT=1, BUSY=0, CRC_STRB=0
  - no DONE
- RST mid-frame: all outputs take their reset values immediately.

## Timing
- START accepted at edge N:
  - BUSY=1 and CRC_CLEAR=1 after edge N
  - CRC_CLEAR=0 after edge N+1
- First TX bit: TX_BIT changes on the edge that samples the first BIT_TICK in DATA.
- CRC strobe: CRC_STRB rises one CLK after the corresponding TX_BIT change, with CRC_BITVAL stable from that same edge. CRC_IN is final two CLK after the last strobe rise; the ≥3-cycle tick spacing guarantees this before it is latched.
- TX_BIT holds between ticks.
- Frame length in ticks is LEN + 15 + 1 + number of stuff bits, plus one final tick that produces DONE.

## Configuration
- CAN_TX_STUFF_EN defined: bit stuffing as described.
- CAN_TX_STUFF_EN undefined: the run counter and stuff logic are removed, no stuff bits are ever emitted, and the frame is exactly LEN+16 bits (test/loopback use).

## Structure
- Package can_pkg holds:
  - state enum (IDLE, CLR, DATA, CRC, DELIM)
  - CAN_CRC_W=15, CAN_STUFF_RUN=5, CAN_RECESSIVE=1'b1
- One sub-module, can_bit_stuffer, holds the run counter and stuff decision. It takes tick, next bit and enable (stuffing region). It returns the emitted bit and an is_stuff flag.
- The CRC unit is instantiated outside this block.

## Test plan
- LEN=1, FRAME[0]=1, with the CRC unit connected:
  - CRC_IN latched = 0x4599
  - TX sequence 1,100010110011001,1 (17 bits), no stuff bits, DONE once
- LEN=6, all zeros, CAN_TX_STUFF_EN defined:
  - TX = 00000 1 0, then 0000 1 00000 1 00000 1 0, then delimiter 1 (26 bits)
  - exactly 6 CRC_STRB pulses
- Same stimulus, CAN_TX_STUFF_EN undefined: 22 bits, all 0 except the final delimiter 1.
- ABORT asserted during the 3rd DATA bit:
  - next cycle IDLE, TX_BIT=1, BUSY=0, no DONE
  - a new START is accepted and CRC_CLEAR pulses again
- START pulsed while BUSY, and START with LEN=0: both ignored, with no CRC_CLEAR and no BUSY change.
- RST asserted mid-CRC field: outputs take their reset values asynchronously, and the next frame after reset is bit-exact with scenario 1.
